// File: rtl/fwd_ctrl_if.sv
// rtl/fwd_ctrl_if.sv - ID-stage hazard/forwarding bundle between the pipeline and fwd_ctrl
// Signals:
//   id_valid, id_rn, id_rm, id_rd, id_reg_write, id_mem_read : instruction currently in ID
//   flush  : squash the ID instruction (taken branch)
//   stall  : load-use hazard, upstream holds PC and IF/ID
//   fwd_a, fwd_b : EX operand mux selects (00 regfile, 01 EX/MEM, 10 MEM/WB, 11 zero)
// Modports: master drives ID info and flush; slave (fwd_ctrl) drives stall and selects.
interface fwd_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    output id_valid, id_rn, id_rm, id_rd, id_reg_write, id_mem_read, flush,
    input  stall, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rd, id_reg_write, id_mem_read, flush,
    output stall, fwd_a, fwd_b
  );
endinterface

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - load-use stall detection and EX operand forwarding control
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : fwd_ctrl_if.slave (ID instruction info and flush in; stall, fwd_a, fwd_b out)
// Parameter:
//   ZERO_REG : register index hardwired to zero; never a forwarding source
module fwd_ctrl #(
  parameter logic [4:0] ZERO_REG = 5'd31
) (
  input logic       clk,
  input logic       reset,
  fwd_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EXMEM   = 2'b01;
  localparam logic [1:0] SEL_MEMWB   = 2'b10;
  localparam logic [1:0] SEL_ZERO    = 2'b11;

  // ID/EX shadow
  logic       idex_valid_q,     idex_valid_d;
  logic [4:0] idex_rn_q,        idex_rn_d;
  logic [4:0] idex_rm_q,        idex_rm_d;
  logic [4:0] idex_rd_q,        idex_rd_d;
  logic       idex_reg_write_q, idex_reg_write_d;
  logic       idex_mem_read_q,  idex_mem_read_d;
  // EX/MEM shadow
  logic       exmem_valid_q,     exmem_valid_d;
  logic [4:0] exmem_rd_q,        exmem_rd_d;
  logic       exmem_reg_write_q, exmem_reg_write_d;
  logic       exmem_mem_read_q,  exmem_mem_read_d;
  // MEM/WB shadow
  logic       memwb_valid_q,     memwb_valid_d;
  logic [4:0] memwb_rd_q,        memwb_rd_d;
  logic       memwb_reg_write_q, memwb_reg_write_d;

  logic       stall_c;
  logic [1:0] fwd_a_c;
  logic [1:0] fwd_b_c;

  // First match wins; EX/MEM is checked before MEM/WB so the newest value is used.
  function automatic logic [1:0] fwd_sel(
    input logic       idex_valid,
    input logic [4:0] src,
    input logic       ex_hit_en,
    input logic [4:0] ex_rd,
    input logic       wb_hit_en,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = SEL_REGFILE;
    if (!idex_valid)                   sel = SEL_REGFILE;
    else if (src == ZERO_REG)          sel = SEL_ZERO;
    else if (ex_hit_en && ex_rd == src) sel = SEL_EXMEM;
    else if (wb_hit_en && wb_rd == src) sel = SEL_MEMWB;
    return sel;
  endfunction

  // Load in EX whose destination is read by the ID instruction.
  always_comb begin
    stall_c = bus.id_valid && !bus.flush && idex_valid_q && idex_mem_read_q &&
              (idex_rd_q != ZERO_REG) &&
              ((idex_rd_q == bus.id_rn) || (idex_rd_q == bus.id_rm));
  end

  always_comb begin
    fwd_a_c = fwd_sel(idex_valid_q, idex_rn_q,
                      exmem_valid_q && exmem_reg_write_q, exmem_rd_q,
                      memwb_valid_q && memwb_reg_write_q, memwb_rd_q);
    fwd_b_c = fwd_sel(idex_valid_q, idex_rm_q,
                      exmem_valid_q && exmem_reg_write_q, exmem_rd_q,
                      memwb_valid_q && memwb_reg_write_q, memwb_rd_q);
  end

  // Outputs are forced quiet while reset is held, since state is not yet cleared then.
  assign bus.stall = stall_c && !reset;
  assign bus.fwd_a = reset ? SEL_REGFILE : fwd_a_c;
  assign bus.fwd_b = reset ? SEL_REGFILE : fwd_b_c;

  always_comb begin
    memwb_valid_d     = exmem_valid_q;
    memwb_rd_d        = exmem_rd_q;
    memwb_reg_write_d = exmem_reg_write_q;

    exmem_valid_d     = idex_valid_q;
    exmem_rd_d        = idex_rd_q;
    exmem_reg_write_d = idex_reg_write_q;
    exmem_mem_read_d  = idex_mem_read_q;

    // Flush and stall both inject a bubble; a bubble can never match a source.
    idex_valid_d      = 1'b0;
    idex_rn_d         = 5'd0;
    idex_rm_d         = 5'd0;
    idex_rd_d         = 5'd0;
    idex_reg_write_d  = 1'b0;
    idex_mem_read_d   = 1'b0;
    if (!bus.flush && !stall_c) begin
      idex_valid_d     = bus.id_valid;
      idex_rn_d        = bus.id_rn;
      idex_rm_d        = bus.id_rm;
      idex_rd_d        = bus.id_rd;
      idex_reg_write_d = bus.id_reg_write && bus.id_valid;
      idex_mem_read_d  = bus.id_mem_read && bus.id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_valid_q      <= 1'b0;
      idex_rn_q         <= 5'd0;
      idex_rm_q         <= 5'd0;
      idex_rd_q         <= 5'd0;
      idex_reg_write_q  <= 1'b0;
      idex_mem_read_q   <= 1'b0;
      exmem_valid_q     <= 1'b0;
      exmem_rd_q        <= 5'd0;
      exmem_reg_write_q <= 1'b0;
      exmem_mem_read_q  <= 1'b0;
      memwb_valid_q     <= 1'b0;
      memwb_rd_q        <= 5'd0;
      memwb_reg_write_q <= 1'b0;
    end else begin
      idex_valid_q      <= idex_valid_d;
      idex_rn_q         <= idex_rn_d;
      idex_rm_q         <= idex_rm_d;
      idex_rd_q         <= idex_rd_d;
      idex_reg_write_q  <= idex_reg_write_d;
      idex_mem_read_q   <= idex_mem_read_d;
      exmem_valid_q     <= exmem_valid_d;
      exmem_rd_q        <= exmem_rd_d;
      exmem_reg_write_q <= exmem_reg_write_d;
      exmem_mem_read_q  <= exmem_mem_read_d;
      memwb_valid_q     <= memwb_valid_d;
      memwb_rd_q        <= memwb_rd_d;
      memwb_reg_write_q <= memwb_reg_write_d;
    end
  end

  // A load result is not available in EX/MEM; the stall must have kept this from happening.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(exmem_mem_read_q && (fwd_a_c == SEL_EXMEM || fwd_b_c == SEL_EXMEM)))
        else $error("fwd_ctrl: forwarding from a load in EX/MEM");
    end
  end

endmodule

// File: doc/fwd_ctrl.md
FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter: ZERO_REG, 31, register index hardwired to zero (XZR); never a forwarding source.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  instruction in ID is real (0 = bubble).
REQ-005 id_rn  input  5  ID first source register (ALU operand A).
REQ-006 id_rm  input  5  ID second source register (ALU operand B).
REQ-007 id_rd  input  5  ID destination register.
REQ-008 id_reg_write  input  1  ID instruction writes id_rd.
REQ-009 id_mem_read  input  1  ID instruction is a load (LDUR).
REQ-010 flush  input  1  squash the ID instruction (taken branch).
REQ-011 stall  output  1  load-use hazard; upstream holds PC and IF/ID this cycle.
REQ-012 fwd_a  output  2  select for EX operand-A 64-bit 4:1 mux: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 zero.
REQ-013 fwd_b  output  2  same encoding, operand-B mux.

Function
REQ-014 Block SHALL hold three internal pipeline registers: IDEX {valid, rn, rm, rd, reg_write, mem_read}, EXMEM {valid, rd, reg_write, mem_read}, MEMWB {valid, rd, reg_write}.
REQ-015 Each rising edge: MEMWB <= EXMEM, EXMEM <= IDEX, unconditionally.
REQ-016 IDEX load priority: reset > flush > stall > normal; flush or stall SHALL load a bubble (valid=0, reg_write=0, mem_read=0); normal loads ID inputs with reg_write/mem_read gated by id_valid.
REQ-017 stall SHALL be combinational: id_valid & !flush & IDEX.valid & IDEX.mem_read & IDEX.rd!=ZERO_REG & (IDEX.rd==id_rn | IDEX.rd==id_rm).
REQ-018 stall SHALL last exactly one cycle per load-use pair (bubble removes the hazard next cycle).
REQ-019 fwd_a SHALL be combinational from registered state only, first match wins: IDEX.valid=0 -> 00; IDEX.rn==ZERO_REG -> 11; EXMEM.reg_write & EXMEM.rd==IDEX.rn -> 01; MEMWB.reg_write & MEMWB.rd==IDEX.rn -> 10; else 00.
REQ-020 fwd_b SHALL follow REQ-019 using IDEX.rm.
REQ-021 Writes to ZERO_REG SHALL never cause forwarding or stall (covered by 11 precedence and REQ-017).
REQ-022 EX/MEM precedence over MEM/WB when both match (newest value wins).
REQ-023 Forwarding from EXMEM when EXMEM.mem_read=1 SHALL be unreachable given REQ-017; an assertion SHALL flag it.
REQ-024 Bubbles SHALL never match (reg_write=0).

Reset
REQ-025 Synchronous reset SHALL clear all valid, reg_write, mem_read bits and rd/rn/rm fields to 0.
REQ-026 During and one cycle after reset: stall=0, fwd_a=00, fwd_b=00.
REQ-027 Reset asserted mid-stall SHALL drop stall on the next edge and discard all in-flight hazards.

Verification
REQ-028 Reset 2 cycles, id_valid=0 -> stall=0, fwd_a=fwd_b=00 throughout.
REQ-029 ADD X1,X2,X3 then ADD X5,X1,X4 back-to-back -> second in EX: fwd_a=01, fwd_b=00, stall=0.
REQ-030 ADD X1 ; NOP ; SUB X6,X7,X1 -> SUB in EX: fwd_b=10.
REQ-031 ADD X1 ; ADD X1 ; ADD X8,X1,X1 -> fwd_a=fwd_b=01 (newest wins).
REQ-032 LDUR X4 ; ADD X9,X4,X2 -> stall=1 one cycle, bubble inserted, then ADD in EX with fwd_a=10; same with flush=1 during hazard -> stall=0, ADD squashed.
REQ-033 ADD X31,X1,X2 ; ADD X3,X31,X31 -> fwd_a=fwd_b=11; LDUR X31 ; ADD using X31 -> stall=0.
